c880_resp_misr: RTL and testbench

- Output response analyzer that sits directly downstream of the c880 circuit-under-test. It consumes the 26-bit response vector (N388..N880, in output-list order) for each applied pattern.
- Each accepted response is compacted into a multiple-input signature register (MISR). After a programmed number of patterns, the final signature is compared against a golden signature.
- Replaces per-pattern gold-file dumps with a single pass/fail verdict plus the signature.

---
 rtl/c880_resp_misr_pkg.sv | 33 +++
 rtl/c880_resp_misr_misr_reg.sv | 36 +++
 rtl/c880_resp_misr.sv | 133 +++++++++++++
 tb/tb_c880_resp_misr.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/c880_resp_misr_pkg.sv
// Shared definitions for the c880 output response analyzer: state encoding,
// default MISR constants and the single-step MISR function, which is also
// reused by the pattern-generator LFSR work.
package dft_ora_pkg;

    // c880 response width: bit 0 = N388 ... bit 25 = N880
    localparam int C880_RESP_W = 26;
    localparam int DEF_SIG_W   = 32;
    localparam int DEF_CNT_W   = 16;

    localparam logic [DEF_SIG_W-1:0] DEF_POLY = 32'h04C11DB7;
    localparam logic [DEF_SIG_W-1:0] DEF_SEED = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPACT = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_e;

    // One Galois MISR step: shift left, fold in the polynomial when the MSB
    // falls out, then xor in the (already zero-extended) parallel data.
    function automatic logic [DEF_SIG_W-1:0] misr_next(
        input logic [DEF_SIG_W-1:0] sig,
        input logic [DEF_SIG_W-1:0] data,
        input logic [DEF_SIG_W-1:0] poly
    );
        logic [DEF_SIG_W-1:0] w_fb;
        w_fb = sig[DEF_SIG_W-1] ? poly : '0;
        return {sig[DEF_SIG_W-2:0], 1'b0} ^ w_fb ^ data;
    endfunction

endpackage

// File: rtl/c880_resp_misr_misr_reg.sv
// Multiple-input signature register: loads SEED on reset or i_load,
// otherwise compacts i_data into the signature on each enabled edge.
module misr_reg
    import dft_ora_pkg::*;
#(
    parameter int                   DATA_W = C880_RESP_W,
    parameter logic [DEF_SIG_W-1:0] POLY   = DEF_POLY,
    parameter logic [DEF_SIG_W-1:0] SEED   = DEF_SEED
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_load,
    input  logic                 i_en,
    input  logic [DATA_W-1:0]    i_data,
    output logic [DEF_SIG_W-1:0] o_sig
);

    logic [DEF_SIG_W-1:0] r_sig;
    logic [DEF_SIG_W-1:0] w_data_ext;

    assign w_data_ext = DEF_SIG_W'(i_data);

    // Seed load has priority over compaction; otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig <= SEED;
        end else if (i_load) begin
            r_sig <= SEED;
        end else if (i_en) begin
            r_sig <= misr_next(r_sig, w_data_ext, POLY);
        end
    end

    assign o_sig = r_sig;

endmodule

// File: rtl/c880_resp_misr.sv
// c880 response analyzer top: run-control FSM, pattern counter and golden
// compare around a MISR. One start pulse compacts num_patterns beats and
// yields a single pass/fail verdict plus the signature.
//
// Handshake: a beat transfers on a rising edge where resp_valid && resp_ready.
// resp_ready is a pure function of state (high only in COMPACT), never of
// resp_valid; the source may hold resp_valid high while resp_ready is low.
module c880_resp_misr
    import dft_ora_pkg::*;
#(
    parameter int                   RESP_W = C880_RESP_W,
    parameter int                   SIG_W  = DEF_SIG_W,    // MISR is DEF_SIG_W bits wide
    parameter logic [DEF_SIG_W-1:0] POLY   = DEF_POLY,
    parameter logic [DEF_SIG_W-1:0] SEED   = DEF_SEED,
    parameter int                   CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  num_patterns,
    input  logic [SIG_W-1:0]  golden_sig,
    input  logic              resp_valid,
    input  logic [RESP_W-1:0] resp_data,
    output logic              resp_ready,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [SIG_W-1:0]  signature,
    output logic [CNT_W-1:0]  pat_count,
    output logic [1:0]        o_dbg_state
);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [CNT_W-1:0]  r_num;
    logic [CNT_W-1:0]  r_count;
    logic [SIG_W-1:0]  r_golden;
    logic              r_pass;
    logic [SIG_W-1:0]  w_sig;
    logic              w_load;
    logic              w_accept;
    logic              w_last;

    // A run may start only from IDLE or DONE; abort overrides both start and accept
    assign w_load   = start && !abort && ((r_state == IDLE) || (r_state == DONE));
    assign w_accept = resp_valid && !abort && (r_state == COMPACT);
    assign w_last   = (r_count + CNT_W'(1)) == r_num;

    misr_reg #(
        .DATA_W (RESP_W),
        .POLY   (POLY),
        .SEED   (SEED)
    ) u_misr (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_en   (w_accept),
        .i_data (resp_data),
        .o_sig  (w_sig)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a zero-length run goes straight to COMPARE
    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        w_state_nxt = (num_patterns != '0) ? COMPACT : COMPARE;
                    end
                end
                COMPACT: begin
                    if (w_accept && w_last) begin
                        w_state_nxt = COMPARE;
                    end
                end
                COMPARE: w_state_nxt = DONE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // State-decoded outputs
    always_comb begin
        resp_ready = (r_state == COMPACT);
        busy       = (r_state == COMPACT) || (r_state == COMPARE);
        done       = (r_state == DONE);
    end

    // Run parameters and accepted-beat counter; held across abort until next start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num    <= '0;
            r_golden <= '0;
            r_count  <= '0;
        end else if (w_load) begin
            r_num    <= num_patterns;
            r_golden <= golden_sig;
            r_count  <= '0;
        end else if (w_accept) begin
            r_count  <= r_count + CNT_W'(1);
        end
    end

    // Verdict: registered in the COMPARE cycle, cleared by abort or a new run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pass <= 1'b0;
        end else if (abort || w_load) begin
            r_pass <= 1'b0;
        end else if (r_state == COMPARE) begin
            r_pass <= (w_sig == r_golden);
        end
    end

    assign pass        = r_pass;
    assign signature   = w_sig;
    assign pat_count   = r_count;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_c880_resp_misr.sv
// Bench for c880_resp_misr: transaction-level reference model checked every
// cycle, literal expectations for the directed cases, randomized runs.
module tb_c880_resp_misr;
  import dft_ora_pkg::*;

  localparam logic [31:0] P_POLY = 32'h04C11DB7;
  localparam logic [31:0] P_SEED = 32'hFFFFFFFF;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] num_patterns;
  logic [31:0] golden_sig;
  logic        resp_valid;
  logic [25:0] resp_data;
  logic        resp_ready;
  logic        busy;
  logic        done;
  logic        pass;
  logic [31:0] signature;
  logic [15:0] pat_count;
  logic [1:0]  dbg_state;

  // second instance with SEED=0
  logic        s_start;
  logic        s_abort;
  logic [15:0] s_num;
  logic [31:0] s_gold;
  logic        s_valid;
  logic [25:0] s_data;
  logic        s_ready;
  logic        s_busy;
  logic        s_done;
  logic        s_pass;
  logic [31:0] s_sig;
  logic [15:0] s_cnt;
  logic [1:0]  s_dbg;

  int errors = 0;
  int checks = 0;

  bit pat7 [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  c880_resp_misr dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .num_patterns(num_patterns), .golden_sig(golden_sig),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(resp_ready),
    .busy(busy), .done(done), .pass(pass), .signature(signature),
    .pat_count(pat_count), .o_dbg_state(dbg_state)
  );

  c880_resp_misr #(.SEED(32'h0)) dut_s0 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .abort(s_abort),
    .num_patterns(s_num), .golden_sig(s_gold),
    .resp_valid(s_valid), .resp_data(s_data), .resp_ready(s_ready),
    .busy(s_busy), .done(s_done), .pass(s_pass), .signature(s_sig),
    .pat_count(s_cnt), .o_dbg_state(s_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // MISR arithmetic: doubling mod 2^32, fold in POLY on carry-out, add data in GF(2)
  function automatic logic [31:0] sig_step(input logic [31:0] s, input logic [25:0] d);
    logic [32:0] dbl;
    dbl = {1'b0, s} * 33'd2;
    return dbl[31:0] ^ (dbl[32] ? P_POLY : 32'h0) ^ {6'b0, d};
  endfunction

  function automatic logic [31:0] fold(input logic [31:0] seed, input logic [25:0] q[$]);
    logic [31:0] s;
    s = seed;
    foreach (q[i]) s = sig_step(s, q[i]);
    return s;
  endfunction

  // ---------------- reference model ----------------
  state_e      m_state;
  logic [31:0] m_sig;
  logic [31:0] m_gold;
  logic [15:0] m_cnt;
  logic [15:0] m_num;
  logic        m_pass;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= IDLE;
      m_sig   <= P_SEED;
      m_cnt   <= 16'd0;
      m_pass  <= 1'b0;
    end else if (abort) begin
      m_state <= IDLE;
      m_pass  <= 1'b0;
    end else begin
      case (m_state)
        IDLE, DONE: if (start) begin
          m_sig   <= P_SEED;
          m_cnt   <= 16'd0;
          m_num   <= num_patterns;
          m_gold  <= golden_sig;
          m_pass  <= 1'b0;
          m_state <= (num_patterns == 16'd0) ? COMPARE : COMPACT;
        end
        COMPACT: if (resp_valid) begin
          m_sig <= sig_step(m_sig, resp_data);
          m_cnt <= m_cnt + 16'd1;
          if (int'(m_cnt) + 1 == int'(m_num)) m_state <= COMPARE;
        end
        COMPARE: begin
          m_pass  <= (m_sig == m_gold);
          m_state <= DONE;
        end
        default: m_state <= IDLE;
      endcase
    end
  end

  // Cycle compare, mid-cycle on the falling edge
  always @(negedge clk) begin
    chk("state", {30'b0, dbg_state}, {30'b0, m_state});
    chk("resp_ready", {31'b0, resp_ready}, {31'b0, m_state == COMPACT});
    chk("busy", {31'b0, busy}, {31'b0, (m_state == COMPACT) || (m_state == COMPARE)});
    chk("done", {31'b0, done}, {31'b0, m_state == DONE});
    chk("signature", signature, m_sig);
    chk("pat_count", {16'b0, pat_count}, {16'b0, m_cnt});
    if (m_state == DONE || m_state == IDLE)
      chk("pass", {31'b0, pass}, {31'b0, m_pass});
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] n, input logic [31:0] g);
    start = 1'b1; num_patterns = n; golden_sig = g;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic v, input logic [25:0] d);
    resp_valid = v; resp_data = d;
    tick();
    resp_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [25:0] q[$];
    logic [25:0] one[$];
    logic [31:0] good;
    logic [31:0] gold;
    int k;

    rst_n = 1'b0; start = 0; abort = 0; num_patterns = 0; golden_sig = 0;
    resp_valid = 0; resp_data = 0;
    s_start = 0; s_abort = 0; s_num = 0; s_gold = 0; s_valid = 0; s_data = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_sig", signature, 32'hFFFFFFFF);
    chk("rst_cnt", {16'b0, pat_count}, 32'd0);
    chk("rst_ready", {31'b0, resp_ready}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_pass", {31'b0, pass}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // single zero beat from seed FFFFFFFF
    do_start(16'd1, 32'hFB3EE249);
    beat(1'b1, 26'h0);
    @(negedge clk);
    chk("one_beat_sig", signature, 32'hFB3EE249);
    chk("one_beat_cmp_busy", {31'b0, busy}, 32'd1);
    chk("one_beat_cmp_done", {31'b0, done}, 32'd0);
    tick();
    @(negedge clk);
    chk("one_beat_done", {31'b0, done}, 32'd1);
    chk("one_beat_pass", {31'b0, pass}, 32'd1);

    // zero-length run
    do_start(16'd0, 32'hFFFFFFFF);
    @(negedge clk);
    chk("zero_ready", {31'b0, resp_ready}, 32'd0);
    chk("zero_busy", {31'b0, busy}, 32'd1);
    tick();
    @(negedge clk);
    chk("zero_done", {31'b0, done}, 32'd1);
    chk("zero_pass", {31'b0, pass}, 32'd1);
    chk("zero_cnt", {16'b0, pat_count}, 32'd0);

    // SEED=0 instance: all-ones beat, matching then mismatching golden
    for (int r = 0; r < 2; r++) begin
      s_start = 1'b1; s_num = 16'd1; s_gold = (r == 0) ? 32'h03FFFFFF : 32'h03FFFFFE;
      tick();
      s_start = 1'b0; s_valid = 1'b1; s_data = 26'h3FFFFFF;
      tick();
      s_valid = 1'b0;
      @(negedge clk);
      chk("s0_sig", s_sig, 32'h03FFFFFF);
      tick();
      @(negedge clk);
      chk("s0_done", {31'b0, s_done}, 32'd1);
      chk("s0_pass", {31'b0, s_pass}, (r == 0) ? 32'd1 : 32'd0);
    end

    // four beats with stalls in between
    q.delete();
    for (int i = 0; i < 4; i++) q.push_back(26'($urandom));
    do_start(16'd4, 32'h0);
    k = 0;
    for (int i = 0; i < 7; i++) begin
      if (pat7[i]) begin
        beat(1'b1, q[k]);
        k++;
      end else begin
        beat(1'b0, 26'($urandom));
      end
    end
    @(negedge clk);
    chk("four_cnt", {16'b0, pat_count}, 32'd4);
    chk("four_ready", {31'b0, resp_ready}, 32'd0);
    chk("four_sig", signature, fold(P_SEED, q));
    tick(); tick();

    // abort together with the second beat
    do_start(16'd4, 32'h0);
    beat(1'b1, q[0]);
    abort = 1'b1; resp_valid = 1'b1; resp_data = q[1];
    tick();
    abort = 1'b0; resp_valid = 1'b0;
    @(negedge clk);
    one.delete(); one.push_back(q[0]);
    chk("abort_cnt", {16'b0, pat_count}, 32'd1);
    chk("abort_sig", signature, fold(P_SEED, one));
    chk("abort_idle", {30'b0, dbg_state}, {30'b0, IDLE});
    chk("abort_pass", {31'b0, pass}, 32'd0);

    // reset in the middle of a run
    do_start(16'd8, 32'h0);
    for (int i = 0; i < 3; i++) beat(1'b1, 26'($urandom));
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_sig", signature, 32'hFFFFFFFF);
    chk("midrst_cnt", {16'b0, pat_count}, 32'd0);
    chk("midrst_ready", {31'b0, resp_ready}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_idle", {30'b0, dbg_state}, {30'b0, IDLE});
    tick();
    rst_n = 1'b1;
    tick();

    // randomized runs
    for (int r = 0; r < 30; r++) begin
      int n;
      int i;
      int cyc;
      int abort_at;
      bit use_good;
      bit do_abort;
      bit aborted;
      n = $urandom_range(0, 10);
      q.delete();
      for (int j = 0; j < n; j++) q.push_back(26'($urandom));
      good = fold(P_SEED, q);
      use_good = 1'($urandom_range(0, 1));
      gold = use_good ? good : (good ^ (32'h1 << $urandom_range(0, 31)));
      do_abort = ($urandom_range(0, 6) == 0);
      abort_at = $urandom_range(0, n);
      aborted = 1'b0;
      do_start(16'(n), gold);
      i = 0;
      cyc = 0;
      while (i < n && cyc < 200) begin
        if (do_abort && i == abort_at) begin
          abort = 1'b1; resp_valid = 1'($urandom_range(0, 1)); resp_data = 26'($urandom);
          tick();
          abort = 1'b0; resp_valid = 1'b0;
          aborted = 1'b1;
          break;
        end
        start = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 3) != 0) begin
          beat(1'b1, q[i]);
          i++;
        end else begin
          beat(1'b0, 26'($urandom));
        end
        start = 1'b0;
        cyc++;
      end
      if (aborted) begin
        @(negedge clk);
        chk("rnd_abort_busy", {31'b0, busy}, 32'd0);
        chk("rnd_abort_cnt", {16'b0, pat_count}, 32'(i));
      end else begin
        chk("rnd_beats_bound", 32'(i), 32'(n));
        @(negedge clk);
        chk("rnd_cmp_busy", {31'b0, busy}, 32'd1);
        tick();
        @(negedge clk);
        chk("rnd_done", {31'b0, done}, 32'd1);
        chk("rnd_pass", {31'b0, pass}, {31'b0, use_good});
        chk("rnd_sig", signature, good);
        chk("rnd_cnt", {16'b0, pat_count}, 32'(n));
      end
      repeat ($urandom_range(0, 2)) tick();
    end

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
